// File: rtl/riscv_pkg.sv
// Shared RV32 constants for the fetch front end: canonical NOP, PC step and
// the default reset/halt fetch addresses.
package riscv_pkg;

  localparam logic [31:0] RV_NOP      = 32'h0000_0013;
  localparam logic [31:0] RV_PC_STEP  = 32'd4;
  localparam logic [31:0] RV_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] RV_HALT_PC  = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, inst} fetch results. Flush empties it in one
// cycle; pointers wrap explicitly so DEPTH need not be a power of two.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Pointer and occupancy next-state; flush overrides push and pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) begin
        tail_d = ptr_inc(tail_q);
      end else begin
        tail_d = tail_q;
      end
      if (pop_i) begin
        head_d = ptr_inc(head_q);
      end else begin
        head_d = head_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset: entries are only observed below count_q.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i && !rst_i) begin
      mem_q[tail_q] <= data_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[head_q];

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: sequential PC generation toward a one-cycle
// synchronous instruction memory, with results queued for ID via valid/ready.
module if_prefetch
  import riscv_pkg::*;
#(
  parameter int WORD_BITWIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [WORD_BITWIDTH-1:0] RESET_PC = WORD_BITWIDTH'(RV_RESET_PC),
  parameter logic [WORD_BITWIDTH-1:0] HALT_PC  = WORD_BITWIDTH'(RV_HALT_PC),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [WORD_BITWIDTH-1:0] inst_addr_o,
  output logic                     inst_ce_o,
  input  logic [WORD_BITWIDTH-1:0] inst_i,
  input  logic                     redirect_i,
  input  logic [WORD_BITWIDTH-1:0] redirect_pc_i,
  output logic                     id_valid_o,
  input  logic                     id_ready_i,
  output logic [WORD_BITWIDTH-1:0] id_pc_o,
  output logic [WORD_BITWIDTH-1:0] id_inst_o,
  output logic [CNT_W-1:0]         occ_o
);

  localparam int W = WORD_BITWIDTH;

  logic [W-1:0]     pc_q, pc_d;
  logic             inflight_q, inflight_d;
  logic [W-1:0]     inflight_pc_q, inflight_pc_d;
  logic [CNT_W-1:0] count_s;
  logic [2*W-1:0]   head_s;
  logic             valid_s, pop_s, push_s, issue_s;
  logic [CNT_W:0]   pending_s;

  // Handshake and issue decisions for this cycle.
  always_comb begin
    valid_s   = (count_s != '0) & ~redirect_i;
    pop_s     = valid_s & id_ready_i;
    push_s    = inflight_q & ~redirect_i;
    // Slots already claimed after this cycle's pop; an issue must leave room.
    pending_s = {1'b0, count_s} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop_s};
    issue_s   = ~rst & ~redirect_i & (pc_q != HALT_PC) & (pending_s < (CNT_W + 1)'(DEPTH));
  end

  // Fetch PC and in-flight tracking next-state.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect_i) begin
      pc_d = redirect_pc_i;
    end else if (issue_s) begin
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
      pc_d          = pc_q + W'(RV_PC_STEP);
    end else begin
      pc_d = pc_q;
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(
    .WIDTH(2 * W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (push_s),
    .pop_i  (pop_s),
    .flush_i(redirect_i),
    .data_i ({inflight_pc_q, inst_i}),
    .count_o(count_s),
    .head_o (head_s)
  );

  assign inst_addr_o = pc_q;
  assign inst_ce_o   = issue_s;
  assign id_valid_o  = valid_s;
  assign id_pc_o     = valid_s ? head_s[2*W-1:W] : '0;
  assign id_inst_o   = valid_s ? head_s[W-1:0] : W'(RV_NOP);
  assign occ_o       = count_s;

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: a cycle-level reference model with a
// scoreboard queue of expected {pc, inst} entries, plus directed scenarios.
module tb_if_prefetch;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] HALT   = 32'hFFFF_FFFC;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, redirect, id_ready;
  logic [31:0] redirect_pc, inst;
  logic [31:0] inst_addr, id_pc, id_inst;
  logic        inst_ce, id_valid;
  logic [2:0]  occ;

  always #5 clk = ~clk;

  if_prefetch #(
    .WORD_BITWIDTH(32),
    .DEPTH(DEPTH),
    .RESET_PC(RST_PC),
    .HALT_PC(HALT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_addr_o  (inst_addr),
    .inst_ce_o    (inst_ce),
    .inst_i       (inst),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .id_valid_o   (id_valid),
    .id_ready_i   (id_ready),
    .id_pc_o      (id_pc),
    .id_inst_o    (id_inst),
    .occ_o        (occ)
  );

  // Synchronous instruction memory, one-cycle read latency.
  always @(posedge clk) inst <= inst_addr ^ KEY;

  logic [31:0] m_pc, m_infl_pc;
  logic        m_infl;
  logic [63:0] m_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_ce = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: compare outputs at negedge, then advance the model at posedge.
  task automatic cycle();
    int          cnt;
    logic        e_valid, e_pop, e_ce;
    logic [63:0] hd;
    @(negedge clk);
    cnt     = m_q.size();
    e_valid = (cnt != 0) && !redirect;
    e_pop   = e_valid && id_ready;
    e_ce    = !rst && !redirect && (m_pc != HALT) &&
              ((cnt + int'(m_infl) - int'(e_pop)) < DEPTH);
    hd      = e_valid ? m_q[0] : {32'h0, NOP};
    check_val("ce", 64'(inst_ce), 64'(e_ce));
    check_val("addr", 64'(inst_addr), 64'(m_pc));
    check_val("valid", 64'(id_valid), 64'(e_valid));
    check_val("id_pc", 64'(id_pc), 64'(hd[63:32]));
    check_val("id_inst", 64'(id_inst), 64'(hd[31:0]));
    check_val("occ", 64'(occ), 64'(cnt));
    if (inst_ce) n_ce++;
    @(posedge clk);
    if (rst) begin
      m_pc = RST_PC; m_infl = 1'b0; m_q.delete();
    end else if (redirect) begin
      m_pc = redirect_pc; m_infl = 1'b0; m_q.delete();
    end else begin
      if (e_pop) void'(m_q.pop_front());
      if (m_infl) m_q.push_back({m_infl_pc, m_infl_pc ^ KEY});
      if (e_ce) begin
        m_infl = 1'b1; m_infl_pc = m_pc; m_pc = m_pc + 32'd4;
      end else begin
        m_infl = 1'b0;
      end
    end
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    @(posedge clk); #1;
    m_pc = RST_PC; m_infl = 1'b0; m_infl_pc = 32'h0; m_q.delete();

    // Reset state, then streaming with ID always ready.
    run(2);
    rst = 1'b0; id_ready = 1'b1;
    run(12);

    // Fill with ID stalled, then release.
    rst = 1'b1; run(1);
    rst = 1'b0; id_ready = 1'b0;
    run(8);
    check_val("full_occ", 64'(occ), 64'd4);
    check_val("full_pc", 64'(inst_addr), 64'h10);
    check_val("full_noce", 64'(inst_ce), 64'd0);
    id_ready = 1'b1; #1;
    check_val("resume_ce", 64'(inst_ce), 64'd1);
    run(6);

    // Redirect with a response in flight and three queued entries.
    rst = 1'b1; run(1);
    rst = 1'b0; id_ready = 1'b0;
    run(4);
    check_val("pre_redir_occ", 64'(occ), 64'd3);
    redirect = 1'b1; redirect_pc = 32'h200;
    run(1);
    redirect = 1'b0; id_ready = 1'b1; #1;
    check_val("redir_occ", 64'(occ), 64'd0);
    check_val("redir_addr", 64'(inst_addr), 64'h200);
    check_val("redir_ce", 64'(inst_ce), 64'd1);
    run(8);

    // Fetch up to HALT_PC, drain, restart via redirect.
    redirect = 1'b1; redirect_pc = HALT - 32'd8; id_ready = 1'b0;
    run(1);
    redirect = 1'b0; n_ce = 0;
    run(6);
    check_val("halt_reqs", 64'(n_ce), 64'd2);
    check_val("halt_occ", 64'(occ), 64'd2);
    id_ready = 1'b1;
    run(4);
    check_val("drain_occ", 64'(occ), 64'd0);
    check_val("halt_noce", 64'(inst_ce), 64'd0);
    redirect = 1'b1; redirect_pc = 32'h40;
    run(1);
    redirect = 1'b0; #1;
    check_val("restart_ce", 64'(inst_ce), 64'd1);
    check_val("restart_addr", 64'(inst_addr), 64'h40);
    run(4);

    // Reset mid-stream with two queued and one in flight.
    rst = 1'b1; run(1);
    rst = 1'b0; id_ready = 1'b0;
    run(3);
    check_val("pre_rst_occ", 64'(occ), 64'd2);
    rst = 1'b1;
    run(1);
    rst = 1'b0; #1;
    check_val("rst_occ", 64'(occ), 64'd0);
    check_val("rst_valid", 64'(id_valid), 64'd0);
    check_val("rst_inst", 64'(id_inst), 64'(NOP));
    check_val("rst_addr", 64'(inst_addr), 64'(RST_PC));
    run(3);

    // Random ready, redirects and occasional resets against the model.
    for (int i = 0; i < 400; i++) begin
      id_ready = 1'($urandom_range(0, 1));
      redirect = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) begin
        redirect_pc = HALT - 32'($urandom_range(0, 3) * 4);
      end else begin
        redirect_pc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      end
      rst = ($urandom_range(0, 63) == 0);
      cycle();
    end
    rst = 1'b0; redirect = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
